// File: rtl/addsub_acc_stream.sv
// Registered unsigned add/subtract unit with accumulator, optional saturation,
// valid/ready streaming handshake, zero flag and saturating transaction counter.
module addsub_acc_stream #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SAT   = 0,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             clr_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic             zero,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] txn_cnt
);

    localparam int unsigned RW = WIDTH + 1;

    logic             accept;
    logic [WIDTH-1:0] lhs;
    logic [WIDTH-1:0] rhs;
    logic [WIDTH:0]   raw;
    logic             flag;
    logic [WIDTH-1:0] low;

    // Single output register: a slot is free when empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Operand select, WIDTH+1 arithmetic and optional saturation of the low bits.
    always_comb begin
        lhs = a;
        rhs = b;
        if (op[1]) begin
            lhs = clr_acc ? '0 : acc;
            rhs = a;
        end
        raw  = op[0] ? (RW'(lhs) - RW'(rhs)) : (RW'(lhs) + RW'(rhs));
        flag = raw[WIDTH];
        low  = raw[WIDTH-1:0];
        if ((SAT != 0) && flag) begin
            low = op[0] ? '0 : '1;
        end
    end

    // Output register with handshake-controlled load/hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= {flag, low};
            zero      <= (low == '0);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Accumulator: accumulate ops take priority; clr_acc alone clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (accept && op[1]) begin
            acc <= low;
        end else if (clr_acc) begin
            acc <= '0;
        end
    end

    // Saturating count of accepted transactions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_cnt <= '0;
        end else if (accept && (txn_cnt != '1)) begin
            txn_cnt <= txn_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_addsub_acc_stream.sv
// Directed self-checking bench: a wrap-around and a saturating instance share stimulus.
module tb_addsub_acc_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic       clr_acc;
    logic       out_ready;

    logic       in_ready0, in_ready1;
    logic       out_valid0, out_valid1;
    logic [4:0] result0, result1;
    logic       zero0, zero1;
    logic [3:0] acc0, acc1;
    logic [7:0] txn0, txn1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addsub_acc_stream #(.WIDTH(4), .SAT(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .op(op), .clr_acc(clr_acc),
        .out_valid(out_valid0), .out_ready(out_ready),
        .result(result0), .zero(zero0), .acc(acc0), .txn_cnt(txn0)
    );

    addsub_acc_stream #(.WIDTH(4), .SAT(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .op(op), .clr_acc(clr_acc),
        .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .zero(zero1), .acc(acc1), .txn_cnt(txn1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [3:0] aa, input logic [3:0] bb,
                          input logic [1:0] oo, input logic c);
        in_valid = v;
        a        = aa;
        b        = bb;
        op       = oo;
        clr_acc  = c;
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic cycle(input logic v, input logic [3:0] aa, input logic [3:0] bb,
                         input logic [1:0] oo, input logic c);
        set_in(v, aa, bb, oo, c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        set_in(1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        chk("reset out_valid", 16'(out_valid0), 16'd0);
        chk("reset result", 16'(result0), 16'd0);
        chk("reset zero", 16'(zero0), 16'd0);
        chk("reset acc", 16'(acc0), 16'd0);
        chk("reset txn", 16'(txn0), 16'd0);
        rst = 1'b0;
        #1;
        chk("in_ready after release", 16'(in_ready0), 16'd1);

        // 5 - 9
        cycle(1'b1, 4'd5, 4'd9, 2'b01, 1'b0);
        chk("sub out_valid", 16'(out_valid0), 16'd1);
        chk("sub wrap result", 16'(result0), 16'b11100);
        chk("sub wrap zero", 16'(zero0), 16'd0);
        chk("sub sat result", 16'(result1), 16'b10000);
        chk("sub sat zero", 16'(zero1), 16'd1);

        // 9 - 9
        cycle(1'b1, 4'd9, 4'd9, 2'b01, 1'b0);
        chk("sub equal result", 16'(result0), 16'd0);
        chk("sub equal zero", 16'(zero0), 16'd1);

        // 15 + 15
        cycle(1'b1, 4'd15, 4'd15, 2'b00, 1'b0);
        chk("add ovf wrap", 16'(result0), 16'b11110);
        chk("add ovf sat", 16'(result1), 16'b11111);

        // Accumulate sequence
        cycle(1'b1, 4'd7, 4'd0, 2'b10, 1'b0);
        chk("acc step1", 16'(acc0), 16'd7);
        cycle(1'b1, 4'd7, 4'd0, 2'b10, 1'b0);
        chk("acc step2", 16'(acc0), 16'd14);
        cycle(1'b1, 4'd3, 4'd0, 2'b10, 1'b0);
        chk("acc step3", 16'(acc0), 16'd1);
        chk("acc step3 result", 16'(result0), 16'b10001);
        chk("acc step3 sat acc", 16'(acc1), 16'd15);
        chk("acc step3 sat result", 16'(result1), 16'b11111);
        cycle(1'b1, 4'd2, 4'd0, 2'b11, 1'b0);
        chk("acc step4", 16'(acc0), 16'd15);
        chk("acc step4 result", 16'(result0), 16'b11111);
        chk("acc step4 sat acc", 16'(acc1), 16'd13);
        chk("acc step4 sat result", 16'(result1), 16'b01101);

        // clr_acc together with an accumulate op
        cycle(1'b1, 4'd4, 4'd0, 2'b10, 1'b1);
        chk("clr+acc acc", 16'(acc0), 16'd4);
        chk("clr+acc result", 16'(result0), 16'b00100);
        chk("clr+acc sat acc", 16'(acc1), 16'd4);

        // clr_acc alone, no accept: acc clears, output drains
        cycle(1'b0, 4'd0, 4'd0, 2'b00, 1'b1);
        chk("clr alone acc", 16'(acc0), 16'd0);
        chk("drain out_valid", 16'(out_valid0), 16'd0);
        chk("txn after 8", 16'(txn0), 16'd8);

        // Load a result then stall with backpressure
        cycle(1'b1, 4'd1, 4'd0, 2'b10, 1'b0);
        chk("pre-stall result", 16'(result0), 16'd1);
        chk("pre-stall acc", 16'(acc0), 16'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 4'd3, 4'd3, 2'b00, i == 0);
            #1;
            chk("stall in_ready", 16'(in_ready0), 16'd0);
            cycle(1'b1, 4'd3, 4'd3, 2'b00, i == 0);
            chk("stall result", 16'(result0), 16'd1);
            chk("stall out_valid", 16'(out_valid0), 16'd1);
            chk("stall txn", 16'(txn0), 16'd9);
        end
        chk("clr in stall acc", 16'(acc0), 16'd0);

        // Release: one transfer per cycle
        out_ready = 1'b1;
        set_in(1'b1, 4'd3, 4'd3, 2'b00, 1'b0);
        #1;
        chk("release in_ready", 16'(in_ready0), 16'd1);
        cycle(1'b1, 4'd3, 4'd3, 2'b00, 1'b0);
        chk("release result1", 16'(result0), 16'd6);
        chk("release txn1", 16'(txn0), 16'd10);
        cycle(1'b1, 4'd4, 4'd4, 2'b00, 1'b0);
        chk("release result2", 16'(result0), 16'd8);
        chk("release txn2", 16'(txn0), 16'd11);
        chk("release out_valid", 16'(out_valid0), 16'd1);

        // Asynchronous reset in the middle of a stall
        cycle(1'b1, 4'd5, 4'd0, 2'b10, 1'b0);
        chk("pre-reset acc", 16'(acc0), 16'd5);
        out_ready = 1'b0;
        cycle(1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
        chk("pre-reset out_valid", 16'(out_valid0), 16'd1);
        rst = 1'b1;
        #1;
        chk("async rst out_valid", 16'(out_valid0), 16'd0);
        chk("async rst result", 16'(result0), 16'd0);
        chk("async rst acc", 16'(acc0), 16'd0);
        chk("async rst txn", 16'(txn0), 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post rst in_ready", 16'(in_ready0), 16'd1);

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 4'd1, 4'd1, 2'b00, 1'b0);
            if (i == 254) chk("txn at 255", 16'(txn0), 16'd255);
        end
        chk("txn saturated", 16'(txn0), 16'd255);
        chk("txn saturated sat", 16'(txn1), 16'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
